// File: rtl/bdcpu_pkg.sv
// Shared types and default widths for the bdcpu memory subsystem.
package bdcpu_pkg;

   localparam int BDCPU_DATA_WIDTH = 8;
   localparam int BDCPU_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      ACK  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/bdcpu_ram.sv
// Program/data RAM: one asynchronous read port for the CPU and one shared read/write port
// whose address, data and write enable are steered by the arbiter.
module bdcpu_ram
   import bdcpu_pkg::*;
#(
   parameter int DATA_WIDTH = BDCPU_DATA_WIDTH,
   parameter int ADDR_WIDTH = BDCPU_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic [ADDR_WIDTH-1:0] rw_address,
   input  logic [DATA_WIDTH-1:0] rw_wdata,
   input  logic                  rw_write_enable,
   output logic [DATA_WIDTH-1:0] rw_rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Contents are deliberately never cleared; reset leaves the loaded program intact.
   always_ff @(posedge clock) begin
      if (rw_write_enable) begin
         mem[rw_address] <= rw_wdata;
      end
   end

   assign rd_data  = mem[rd_address];
   assign rw_rdata = mem[rw_address];

endmodule

// File: rtl/bdcpu_mem_arbiter.sv
// Shares the bdcpu RAM between the CPU (always first) and the host loader port; a host that
// has waited MAX_WAIT busy cycles steals exactly one cycle by holding the CPU.
module bdcpu_mem_arbiter
   import bdcpu_pkg::*;
#(
   parameter int DATA_WIDTH = BDCPU_DATA_WIDTH,
   parameter int ADDR_WIDTH = BDCPU_ADDR_WIDTH,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpu_output_enable,
   input  logic                  cpu_write_enable,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_hold,
   input  logic                  host_req,
   input  logic                  host_write,
   input  logic [ADDR_WIDTH-1:0] host_address,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata
);

   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   arb_state_t            state;
   arb_state_t            state_next;
   logic [3:0]            wait_cnt;
   logic [3:0]            wait_cnt_next;
   logic                  cpu_busy;
   logic                  host_access;
   logic                  host_access_live;
   logic                  cpu_write_ok;
   logic [ADDR_WIDTH-1:0] ram_rw_address;
   logic [DATA_WIDTH-1:0] ram_rw_wdata;
   logic                  ram_write_enable;
   logic [DATA_WIDTH-1:0] ram_rw_rdata;

   assign cpu_busy = cpu_output_enable | cpu_write_enable;
   assign cpu_hold = (state == HOLD);
   assign host_ack = (state == ACK);

   // An idle CPU always wins the race against the wait counter in WAIT.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      host_access   = 1'b0;
      case (state)
         IDLE: begin
            if (host_req) begin
               if (!cpu_busy) begin
                  host_access = 1'b1;
                  state_next  = ACK;
               end else begin
                  state_next    = WAIT;
                  wait_cnt_next = 4'd1;
               end
            end
         end
         WAIT: begin
            if (!host_req) begin
               state_next = IDLE;
            end else if (!cpu_busy) begin
               host_access = 1'b1;
               state_next  = ACK;
            end else if (wait_cnt == WAIT_LIMIT) begin
               state_next = HOLD;
            end else begin
               wait_cnt_next = wait_cnt + 4'd1;
            end
         end
         HOLD: begin
            host_access = 1'b1;
            state_next  = ACK;
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Reset abandons an in-flight host access so nothing is written or captured.
   assign host_access_live = host_access & ~reset;
   assign cpu_write_ok     = cpu_write_enable & ~cpu_hold & ~host_access;

   always_comb begin
      ram_rw_address   = cpu_address;
      ram_rw_wdata     = cpu_wdata;
      ram_write_enable = cpu_write_ok;
      if (host_access_live) begin
         ram_rw_address   = host_address;
         ram_rw_wdata     = host_wdata;
         ram_write_enable = host_write;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         host_rdata <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (host_access_live && !host_write) begin
            host_rdata <= ram_rw_rdata;
         end
      end
   end

   bdcpu_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clock          (clock),
      .rd_address     (cpu_address),
      .rd_data        (cpu_rdata),
      .rw_address     (ram_rw_address),
      .rw_wdata       (ram_rw_wdata),
      .rw_write_enable(ram_write_enable),
      .rw_rdata       (ram_rw_rdata)
   );

endmodule
